// File: rtl/ascii_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ascii_pkg
//  Description : Shared ASCII constants, the nibble-to-hex-character encoder
//                and the state encoding of the hex printer.
//  Revision    : 1.0 - initial release
// ============================================================================
package ascii_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;

    // Printer states; the fourth code is unused and recovers to IDLE.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    // Uppercase hex digit for one nibble: 0-9 -> '0'..'9', 10-15 -> 'A'..'F'.
    function automatic logic [7:0] hex2ascii(input logic [3:0] nibble);
        if (nibble < 4'd10) begin
            return ASCII_0 + {4'd0, nibble};
        end
        return ASCII_A + {4'd0, nibble} - 8'd10;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ascii_hex_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : ascii_hex_tx_if
//  Description : Request-side and UART-side handshake bundle of the hex
//                printer. The slave modport is the printer; the master
//                modport is whatever issues requests and plays the UART.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ascii_hex_tx_if #(
    parameter int NIBBLES = 4
);
    logic                   start;
    logic [4*NIBBLES-1:0]   data;
    logic                   busy;
    logic                   done_tick;
    logic                   tx_start;
    logic [7:0]             tx_din;
    logic                   tx_done_tick;

    modport master (
        output start,
        output data,
        output tx_done_tick,
        input  busy,
        input  done_tick,
        input  tx_start,
        input  tx_din
    );

    modport slave (
        input  start,
        input  data,
        input  tx_done_tick,
        output busy,
        output done_tick,
        output tx_start,
        output tx_din
    );
endinterface
`default_nettype wire

// File: rtl/ascii_hex_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ascii_hex_tx
//  Description : Latches a word, prints it as uppercase ASCII hex (MS nibble
//                first, optional CR LF) one character at a time through the
//                UART transmitter's tx_start / din / tx_done_tick handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module ascii_hex_tx
    import ascii_pkg::*;
#(
    parameter int NIBBLES   = 4,
    parameter int SEND_CRLF = 1
) (
    input  wire logic       clk,
    input  wire logic       reset,
    ascii_hex_tx_if.slave   bus
);

    localparam int         W    = 4 * NIBBLES;
    localparam int         L    = NIBBLES + 2 * SEND_CRLF;
    localparam logic [3:0] LAST = 4'(L - 1);

    logic [1:0]   r_state;
    logic [3:0]   r_idx;
    logic [W-1:0] r_word;
    logic         r_busy;
    logic         r_done;
    logic         r_tx_start;
    logic [7:0]   r_tx_din;

    logic [3:0]   w_nib;
    logic [7:0]   w_char;

    // Character for the current index: hex digit, then CR, then LF.
    always_comb begin
        w_nib  = 4'd0;
        w_char = 8'h00;
        for (int k = 0; k < NIBBLES; k++) begin
            if (r_idx == 4'(k)) begin
                w_nib = r_word[4*(NIBBLES-1-k) +: 4];
            end
        end
        if (r_idx < 4'(NIBBLES)) begin
            w_char = hex2ascii(w_nib);
        end else if (r_idx == 4'(NIBBLES)) begin
            w_char = ASCII_CR;
        end else begin
            w_char = ASCII_LF;
        end
    end

    // Frame sequencer: accept, strobe each character, wait for its completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_idx      <= 4'd0;
            r_word     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_din   <= 8'h00;
        end else begin
            r_tx_start <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_busy <= 1'b0;
                    if (bus.start) begin
                        r_word  <= bus.data;
                        r_idx   <= 4'd0;
                        r_busy  <= 1'b1;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    // Byte and strobe become visible together next cycle.
                    r_tx_din   <= w_char;
                    r_tx_start <= 1'b1;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    if (bus.tx_done_tick) begin
                        if (r_idx == LAST) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_state <= LOAD;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done_tick = r_done;
    assign bus.tx_start  = r_tx_start;
    assign bus.tx_din    = r_tx_din;

endmodule
`default_nettype wire

// File: tb/tb_ascii_hex_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ascii_hex_tx
//  Description : Bench for ascii_hex_tx. Two instances: 4 nibbles with CR LF
//                and 2 nibbles without. A UART responder returns
//                tx_done_tick 20 cycles after each tx_start.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ascii_hex_tx;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cyc_n = 0;

    logic [1:0]  st      = '0;
    logic [1:0]  spur    = '0;
    logic [1:0]  td_resp = '0;
    logic [31:0] dt [2];

    logic [1:0]  ob_busy, ob_done, ob_txs;
    logic [7:0]  ob_din [2];

    ascii_hex_tx_if #(.NIBBLES(4)) bus4 ();
    ascii_hex_tx_if #(.NIBBLES(2)) bus2 ();

    ascii_hex_tx #(.NIBBLES(4), .SEND_CRLF(1)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    ascii_hex_tx #(.NIBBLES(2), .SEND_CRLF(0)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    assign bus4.start        = st[0];
    assign bus4.data         = dt[0][15:0];
    assign bus4.tx_done_tick = td_resp[0] | spur[0];
    assign bus2.start        = st[1];
    assign bus2.data         = dt[1][7:0];
    assign bus2.tx_done_tick = td_resp[1] | spur[1];

    assign ob_busy   = {bus2.busy, bus4.busy};
    assign ob_done   = {bus2.done_tick, bus4.done_tick};
    assign ob_txs    = {bus2.tx_start, bus4.tx_start};
    assign ob_din[0] = bus4.tx_din;
    assign ob_din[1] = bus2.tx_din;

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // ------------------------------------------------------------------
    // Helpers and reference rules
    // ------------------------------------------------------------------
    task automatic chkv(input string nm, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     nm, got, got, exp, exp, cyc_n);
        end
    endtask

    function automatic int nib_of(input int d);
        return (d == 0) ? 4 : 2;
    endfunction

    function automatic int len_of(input int d);
        return (d == 0) ? 6 : 2;
    endfunction

    // k-th character of the printed frame, straight from the encoding rules.
    function automatic int char_of(input int d, input logic [31:0] w, input int k);
        int nb;
        int n;
        nb = nib_of(d);
        if (k < nb) begin
            n = int'((w >> (4 * (nb - 1 - k))) & 32'hF);
            return (n < 10) ? (48 + n) : (65 + n - 10);
        end
        return (k == nb) ? 13 : 10;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: expected outputs per cycle, from the timing rules
    // ------------------------------------------------------------------
    logic        m_busy [2];
    logic        m_done [2];
    logic        m_txs  [2];
    logic [7:0]  m_din  [2];
    logic        m_pend [2];   // next cycle carries a tx_start
    logic        m_wait [2];   // a character is outstanding at the UART
    int          m_idx  [2];
    logic [31:0] m_word [2];

    logic [7:0]  logq [2][2048];
    int          logc [2][2048];
    int          logn [2];
    int          ndone [2];

    task automatic model_reset(input int d);
        m_busy[d] = 1'b0; m_done[d] = 1'b0; m_txs[d] = 1'b0; m_din[d] = 8'h00;
        m_pend[d] = 1'b0; m_wait[d] = 1'b0; m_idx[d]  = 0;
    endtask

    task automatic model_step(input int d);
        logic nb, nd, nt, tdi;
        logic [7:0] nn;
        nb  = m_busy[d];
        nd  = 1'b0;
        nt  = 1'b0;
        nn  = m_din[d];
        tdi = td_resp[d] | spur[d];
        if (!m_busy[d] && st[d]) begin
            m_word[d] = dt[d];
            m_idx[d]  = 0;
            nb        = 1'b1;
            m_pend[d] = 1'b1;
        end else if (m_pend[d]) begin
            nt        = 1'b1;
            nn        = 8'(char_of(d, m_word[d], m_idx[d]));
            m_pend[d] = 1'b0;
            m_wait[d] = 1'b1;
        end else if (m_wait[d] && tdi) begin
            m_wait[d] = 1'b0;
            if (m_idx[d] == len_of(d) - 1) begin
                nd = 1'b1;
                nb = 1'b0;
            end else begin
                m_idx[d]  = m_idx[d] + 1;
                m_pend[d] = 1'b1;
            end
        end
        m_busy[d] = nb;
        m_done[d] = nd;
        m_txs[d]  = nt;
        m_din[d]  = nn;
    endtask

    // Compare process: every cycle, both instances, all outputs.
    initial begin
        for (int d = 0; d < 2; d++) begin
            model_reset(d);
            m_word[d] = '0;
            logn[d]   = 0;
            ndone[d]  = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (reset) model_reset(d);
                chkv($sformatf("dut%0d busy", d),      int'(ob_busy[d]), int'(m_busy[d]));
                chkv($sformatf("dut%0d done_tick", d), int'(ob_done[d]), int'(m_done[d]));
                chkv($sformatf("dut%0d tx_start", d),  int'(ob_txs[d]),  int'(m_txs[d]));
                chkv($sformatf("dut%0d tx_din", d),    int'(ob_din[d]),  int'(m_din[d]));
                if (ob_txs[d]) begin
                    logq[d][logn[d]] = ob_din[d];
                    logc[d][logn[d]] = cyc_n;
                    if (logn[d] < 2047) logn[d] = logn[d] + 1;
                end
                if (ob_done[d]) ndone[d] = ndone[d] + 1;
                if (!reset) model_step(d);
            end
        end
    end

    // UART responder: tx_done_tick exactly 20 cycles after each tx_start.
    initial begin
        int cnt [2];
        cnt[0] = 0;
        cnt[1] = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (ob_txs[d]) begin
                    cnt[d]     = 20;
                    td_resp[d] = 1'b0;
                end else if (cnt[d] > 0) begin
                    cnt[d]     = cnt[d] - 1;
                    td_resp[d] = (cnt[d] == 0);
                end else begin
                    td_resp[d] = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus (driver sits at #1 after each rising edge)
    // ------------------------------------------------------------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int d, input logic [31:0] w);
        st[d] = 1'b1;
        dt[d] = w;
        cyc(1);
        st[d] = 1'b0;
        dt[d] = $urandom;
    endtask

    task automatic wait_done(input int d, input int budget, output int dn);
        dn = -1;
        for (int i = 0; i < budget; i++) begin
            if (ob_done[d]) begin
                dn = cyc_n;
                return;
            end
            cyc(1);
        end
        tests++;
        fails++;
        $display("FAIL dut%0d done_tick timeout after %0d cycles", d, budget);
    endtask

    task automatic wait_chars(input int d, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (logn[d] >= target) return;
            cyc(1);
        end
        tests++;
        fails++;
        $display("FAIL dut%0d tx_start count timeout, have %0d want %0d", d, logn[d], target);
    endtask

    task automatic chk_seq(input string nm, input int d, input int b,
                           input logic [95:0] e, input int n);
        logic [95:0] ev;
        ev = e;
        chkv({nm, " count"}, logn[d] - b, n);
        for (int i = 0; i < n; i++) begin
            chkv($sformatf("%s char%0d", nm, i), int'(logq[d][b + i]), int'(ev[8*(n-1-i) +: 8]));
        end
    endtask

    initial begin
        int b, t0, dn, dn1, nd0, nb;
        logic [31:0] w;
        dt[0] = '0;
        dt[1] = '0;
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc_n);
        $fatal(1, "watchdog");
    end

    initial begin
        int b, t0, dn, dn1, nd0, nb, d, len;
        logic [31:0] w;
        repeat (3) @(posedge clk);
        #1;
        chkv("reset tx_din", int'(ob_din[0]), 0);
        chkv("reset busy", int'(ob_busy[0]), 0);
        reset = 1'b0;
        cyc(2);

        // 1A3F with CR LF, latency and spacing pinned by hand.
        b = logn[0]; nd0 = ndone[0]; t0 = cyc_n;
        pulse(0, 32'h1A3F);
        wait_done(0, 400, dn);
        chk_seq("seq_1A3F", 0, b, 96'h31_41_33_46_0D_0A, 6);
        chkv("first tx_start latency", logc[0][b] - t0, 2);
        chkv("char spacing", logc[0][b + 1] - logc[0][b], 22);
        chkv("done latency", dn - logc[0][b + 5], 21);
        cyc(1);
        chkv("done count 1A3F", ndone[0] - nd0, 1);

        // Back-to-back: second start in the done_tick cycle.
        b = logn[0]; nd0 = ndone[0];
        pulse(0, 32'h0000);
        wait_done(0, 400, dn);
        pulse(0, 32'hFFFF);
        wait_done(0, 400, dn1);
        chk_seq("seq_b2b", 0, b, 96'h30_30_30_30_0D_0A_46_46_46_46_0D_0A, 12);
        chkv("b2b restart gap", logc[0][b + 6] - dn, 2);
        cyc(1);
        chkv("done count b2b", ndone[0] - nd0, 2);

        // Start during char 2 is dropped.
        b = logn[0];
        pulse(0, 32'hABCD);
        wait_chars(0, b + 3, 200);
        pulse(0, 32'h1234);
        wait_done(0, 400, dn);
        chk_seq("seq_drop", 0, b, 96'h41_42_43_44_0D_0A, 6);
        cyc(30);
        chkv("no extra frame", logn[0] - b, 6);

        // Spurious tx_done_tick in IDLE and in the LOAD cycle.
        spur[0] = 1'b1; cyc(1); spur[0] = 1'b0; cyc(2);
        b = logn[0];
        st[0] = 1'b1; dt[0] = 32'hC0DE; cyc(1);
        st[0] = 1'b0; spur[0] = 1'b1; cyc(1);
        spur[0] = 1'b0;
        wait_done(0, 400, dn);
        chk_seq("seq_spur", 0, b, 96'h43_30_44_45_0D_0A, 6);

        // Reset while waiting on char 3.
        b = logn[0];
        pulse(0, 32'h5A5A);
        wait_chars(0, b + 4, 300);
        cyc(5);
        reset = 1'b1;
        #2;
        chkv("midreset busy", int'(ob_busy[0]), 0);
        chkv("midreset tx_din", int'(ob_din[0]), 0);
        chkv("midreset tx_start", int'(ob_txs[0]), 0);
        cyc(2);
        reset = 1'b0;
        nb = logn[0];
        cyc(60);
        chkv("no tx_start after reset", logn[0] - nb, 0);
        b = logn[0];
        pulse(0, 32'h0001);
        wait_done(0, 400, dn);
        chk_seq("seq_after_reset", 0, b, 96'h30_30_30_31_0D_0A, 6);

        // Two nibbles, no CR LF.
        b = logn[1];
        pulse(1, 32'h9E);
        wait_done(1, 200, dn);
        chk_seq("seq_9E", 1, b, 96'h39_45, 2);
        chkv("n2 done latency", dn - logc[1][b + 1], 21);

        // Randomized frames on both instances.
        for (int it = 0; it < 30; it++) begin
            d   = int'($urandom_range(0, 1));
            len = len_of(d);
            w   = $urandom;
            b   = logn[d];
            if ($urandom_range(0, 3) == 0) begin
                spur[d] = 1'b1; cyc(1); spur[d] = 1'b0;
            end
            pulse(d, w);
            if ($urandom_range(0, 1) == 1) begin
                cyc(int'($urandom_range(1, 30)));
                if (ob_busy[d]) pulse(d, $urandom);
            end
            wait_done(d, 600, dn);
            chkv("rand count", logn[d] - b, len);
            for (int k = 0; k < len; k++) begin
                chkv($sformatf("rand dut%0d char%0d", d, k), int'(logq[d][b + k]), char_of(d, w, k));
            end
            cyc(int'($urandom_range(0, 3)));
        end

        cyc(5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
